// File: rtl/led_arbiter_pkg.sv
// Shared types and constants for the LED arbiter: state encoding,
// requester count, and counter widths.
package led_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int N_REQ  = 4;
    localparam int GID_W  = 2;
    localparam int HOLD_W = 24;
    localparam int GAP_W  = 16;

    function automatic logic [N_REQ-1:0] onehot(input logic [GID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_arbiter_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so that active-low inputs read as released.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter granting one of four button requesters a shared LED
// for up to HOLD_CYCLES, followed by a GAP_CYCLES dark interval.
//
// state    | meaning
// ST_IDLE  | no grant, LEDs off, waiting for any request
// ST_GRANT | requester grant_id owns the LED, hold counter running
// ST_GAP   | LEDs off, gap counter running, requests ignored
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 6_000_000,
    parameter int GAP_CYCLES  = 600
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] btn_n,
    output logic [N_REQ-1:0] led,
    output logic [GID_W-1:0] grant_id,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    logic [N_REQ-1:0]  w_btn_sync;
    logic [N_REQ-1:0]  w_req;
    logic              w_any;
    logic [GID_W-1:0]  w_winner;

    state_t            r_state;
    logic [N_REQ-1:0]  r_led;
    logic [GID_W-1:0]  r_grant_id;
    logic              r_busy;
    logic [HOLD_W-1:0] r_hold;
    logic [GAP_W-1:0]  r_gap;

    sync_2ff #(.WIDTH(N_REQ)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (btn_n),
        .o_q   (w_btn_sync)
    );

    assign w_req = ~w_btn_sync;

    // Scan starts one past the last grantee so that it gets lowest priority.
    always_comb begin
        w_winner = r_grant_id;
        w_any    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_any && w_req[r_grant_id + GID_W'(i)]) begin
                w_winner = r_grant_id + GID_W'(i);
                w_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_led      <= '0;
            r_grant_id <= GID_W'(N_REQ - 1);
            r_busy     <= 1'b0;
            r_hold     <= '0;
            r_gap      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_winner;
                        r_led      <= onehot(w_winner);
                        r_busy     <= 1'b1;
                        r_hold     <= HOLD_LOAD;
                    end else begin
                        r_led  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!w_req[r_grant_id] || (r_hold == '0)) begin
                        r_state <= ST_GAP;
                        r_led   <= '0;
                        r_gap   <= GAP_LOAD;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                ST_GAP: begin
                    // The last gap cycle doubles as the idle decision so the
                    // dark interval is exactly GAP_CYCLES long.
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (w_any) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_winner;
                        r_led      <= onehot(w_winner);
                        r_busy     <= 1'b1;
                        r_hold     <= HOLD_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign led      = r_led;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 6_000_000, maximum grant length in clk cycles (1 s at 6 MHz); legal range 1..2^24-1.
REQ-002 Parameter GAP_CYCLES, default 600, idle cycles with all LEDs off between grants; legal range 1..2^16-1.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 btn_n  input  4  raw active-low button requests, asynchronous to clk; bit i = requester i.
REQ-006 led  output  4  one-hot grant indicator; bit i high = requester i owns the shared indicator.
REQ-007 grant_id  output  2  index of the current or most recent grantee.
REQ-008 busy  output  1  high in GRANT and GAP states.

Function
REQ-009 Each btn_n bit SHALL pass through a 2-flop synchronizer; req[i] = NOT synchronized btn_n[i].
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-011 IDLE: led = 0000; if any req bit is set, select a winner, load the hold counter with HOLD_CYCLES-1, set grant_id to the winner, and go to GRANT; otherwise stay in IDLE.
REQ-012 Winner selection SHALL be round-robin: scan the requesters starting at grant_id+1 mod 4 and take the first set req bit; wrap-around from 3 to 0 applies.
REQ-013 GRANT: led = one-hot(grant_id); the hold counter decrements once per cycle.
REQ-014 GRANT exits to GAP when req[grant_id] is clear OR the hold counter equals 0, whichever occurs first. If both occur in the same cycle, GRANT exits once.
REQ-015 GAP: led = 0000; load the gap counter with GAP_CYCLES-1 on entry; decrement per cycle; go to IDLE when it equals 0.
REQ-016 Requests arriving or releasing during GAP SHALL have no effect until IDLE.
REQ-017 Latency: btn_n falling before clk edge k, with FSM in IDLE, SHALL give led high after edge k+2 (two synchronizer stages plus one state register).
REQ-018 A sole continuous requester SHALL be re-granted after each GAP: it holds for HOLD_CYCLES, then sees GAP_CYCLES off, repeating.
REQ-019 With multiple requests held, grants SHALL rotate in ascending index order skipping idle requesters; no requester waits more than 3 grants.
REQ-020 led SHALL never have more than one bit set; led and busy SHALL be registered outputs.
REQ-021 Counters SHALL be sized to the parameter widths, unsigned, and shall never wrap below 0.

Reset
REQ-022 While rst_n is low, the block SHALL force: state = IDLE, led = 0000, busy = 0, grant_id = 3 (so that the first round-robin scan starts at 0), counters = 0, synchronizer flops = 1 (released).
REQ-023 Reset asserted mid-GRANT or mid-GAP SHALL clear led within the same cycle (asynchronously), with no further grant until after release.
REQ-024 After rst_n rises, the first grant SHALL take at least the REQ-017 latency.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE, GRANT, GAP), the requester count constant (4), and the grant_id width constant (2).
REQ-026 The synchronizer SHALL be one sub-module, sync_2ff, parameterized by width and instantiated once with width 4; the round-robin pick stays inline.

Verification (HOLD_CYCLES=8, GAP_CYCLES=2)
REQ-027 Reset then btn_n=1110 held -> led=0001 appears 3 edges after the press, stays 8 cycles, is 0000 for 2 cycles, then is 0001 again; grant_id=0.
REQ-028 btn_n=0000 held -> led sequence 0001, 0010, 0100, 1000, 0001, with each grant 8 cycles long and 2-cycle gaps between grants.
REQ-029 btn_n=1101 pressed, then released after 3 cycles of GRANT -> led drops to 0000 in the cycle after the synchronized release, busy stays 1 for 2 gap cycles, then state returns to IDLE.
REQ-030 With grant_id=3, btn_n=0110 (requesters 0 and 3) -> next grant is requester 0 (wrap-around), then requester 3.
REQ-031 rst_n pulsed low during GRANT -> led=0000 and busy=0 immediately; after release, grant_id=3 and the next grant follows the REQ-017 latency.
REQ-032 Requester 1 releases in exactly the cycle its hold counter reaches 0 -> one transition to GAP, no extra grant cycle.
